// File: rtl/inst_prefetch_queue_pkg.sv
// inst_prefetch_queue_pkg: shared core widths, PC step and the prefetch queue entry layout
package inst_prefetch_queue_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_pq_fifo.sv
// pq_fifo: power-of-two synchronous FIFO with occupancy count and single-cycle flush
module pq_fifo
    import inst_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W = XLEN + ILEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // pointers and occupancy; flush discards everything and wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset; only entries below count are ever presented
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher feeding decode; PREFETCH_BYPASS_EN lets a returning word skip the empty queue
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [ILEN-1:0] imem_data_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_addr_i,
    input  logic            stall_i,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] flight_pc;
    logic            in_flight;
    logic [CW-1:0]   count;
    logic            empty;
    logic            push;
    logic            pop;
    logic            req;
    fetch_entry_t    head;
    fetch_entry_t    ret;
    fetch_entry_t    show;

    assign ret = {flight_pc, imem_data_i};

    // a request is only issued when the queue can still absorb every outstanding word
    assign req = !rst && !branch_i && (count + CW'(in_flight) < CW'(DEPTH));
    assign pop = !empty && !stall_i && !branch_i;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass  = empty && in_flight;
    assign push    = in_flight && !branch_i && !(bypass && !stall_i);
    assign valid_o = !branch_i && (!empty || in_flight);
    assign show    = bypass ? ret : head;
`else
    assign push    = in_flight && !branch_i;
    assign valid_o = !branch_i && !empty;
    assign show    = head;
`endif

    assign imem_req_o  = req;
    assign imem_addr_o = fetch_pc;
    assign inst_o      = valid_o ? show.inst : '0;
    assign pc_o        = valid_o ? show.pc : '0;

    // fetch address and the single in-flight tag; a branch retargets and kills the outstanding word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            flight_pc <= '0;
            in_flight <= 1'b0;
        end else if (branch_i) begin
            fetch_pc  <= branch_addr_i;
            in_flight <= 1'b0;
        end else begin
            in_flight <= req;
            if (req) begin
                fetch_pc  <= next_pc(fetch_pc);
                flight_pc <= fetch_pc;
            end
        end
    end

    pq_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN + ILEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_i),
        .push  (push),
        .pop   (pop),
        .wdata (ret),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: randomized and directed checks of the prefetch queue against a queue-of-requests model
module tb_inst_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        stall_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] m_pc = RESET_PC;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        o_v;
    logic        o_rq;
    logic [31:0] o_pc;
    logic [31:0] o_ad;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .stall_i       (stall_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) imem_data_i <= word(imem_addr_o);

    task automatic model_reset();
        pend.delete();
        m_pc = RESET_PC;
        cyc  = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        branch_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // one cycle: drive, compare against the model, advance the model, move to the next falling edge
    task automatic tick(input logic br, input logic [31:0] ba, input logic st);
        logic exp_req;
        logic exp_valid;
        branch_i = br;
        branch_addr_i = ba;
        stall_i = st;
        #1;
        exp_req = !br && pend.size() < DEPTH;
        exp_valid = 1'b0;
        if (!br && pend.size() > 0) exp_valid = (cyc - pend[0].cyc) >= LAT;
        o_v = valid_o;
        o_pc = pc_o;
        o_rq = imem_req_o;
        o_ad = imem_addr_o;
        checks++;
        if (imem_req_o !== exp_req) begin
            errors++;
            $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req_o, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (imem_addr_o !== m_pc) begin
                errors++;
                $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, imem_addr_o, m_pc);
            end
        end
        checks++;
        if (valid_o !== exp_valid) begin
            errors++;
            $display("FAIL valid cyc %0d: got %b expected %b", cyc, valid_o, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (pc_o !== pend[0].pc || inst_o !== word(pend[0].pc)) begin
                errors++;
                $display("FAIL head cyc %0d: got pc %h inst %h expected pc %h inst %h",
                         cyc, pc_o, inst_o, pend[0].pc, word(pend[0].pc));
            end
        end
        if (br) begin
            pend.delete();
            m_pc = ba;
        end else begin
            if (exp_valid && !st) void'(pend.pop_front());
            if (exp_req) begin
                pend.push_back('{pc: m_pc, cyc: cyc});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req %b valid %b inst %h pc %h expected all zero",
                     imem_req_o, valid_o, inst_o, pc_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(1'b0, 32'h0, 1'b0);
        checks++;
        if (o_rq !== 1'b1 || o_ad !== RESET_PC) begin
            errors++;
            $display("FAIL first_request: got req %b addr %h expected 1 %h", o_rq, o_ad, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int nv;
        int first;
        nv = 0;
        first = -1;
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            if (o_v === 1'b1) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first !== LAT || nv !== 12 - LAT) begin
            errors++;
            $display("FAIL stream_latency: got first valid %0d count %0d expected %0d %0d",
                     first, nv, LAT, 12 - LAT);
        end
    endtask

    task automatic test_stall();
        reset_dut();
        repeat (10) tick(1'b0, 32'h0, 1'b1);
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: got req %b valid %b expected 0 1", imem_req_o, valid_o);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            checks++;
            if (o_v !== 1'b1 || o_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_drain %0d: got valid %b pc %h expected 1 %h", i, o_v, o_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        bit seen20;
        bit found;
        seen20 = 1'b0;
        found = 1'b0;
        reset_dut();
        repeat (9) tick(1'b0, 32'h0, 1'b0);
        checks++;
        if (o_rq !== 1'b1 || o_ad !== 32'h20) begin
            errors++;
            $display("FAIL branch_setup: got req %b addr %h expected 1 00000020", o_rq, o_ad);
        end
        tick(1'b1, 32'h100, 1'b0);
        checks++;
        if (o_v !== 1'b0) begin
            errors++;
            $display("FAIL branch_valid_low: got %b expected 0", o_v);
        end
        tick(1'b0, 32'h0, 1'b0);
        checks++;
        if (o_rq !== 1'b1 || o_ad !== 32'h100) begin
            errors++;
            $display("FAIL branch_target_req: got req %b addr %h expected 1 00000100", o_rq, o_ad);
        end
        for (int i = 0; i < 8; i++) begin
            if (o_v === 1'b1 && o_pc === 32'h20) seen20 = 1'b1;
            if (o_v === 1'b1 && !found) begin
                found = 1'b1;
                checks++;
                if (o_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL branch_first_pc: got %h expected 00000100", o_pc);
                end
            end
            tick(1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (!found || seen20) begin
            errors++;
            $display("FAIL branch_kill: got found %b seen20 %b expected 1 0", found, seen20);
        end
    endtask

    task automatic test_branch_stall_full();
        bit found;
        found = 1'b0;
        reset_dut();
        repeat (6) tick(1'b0, 32'h0, 1'b1);
        tick(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            if (o_v === 1'b1) begin
                found = 1'b1;
                checks++;
                if (o_pc !== 32'h200) begin
                    errors++;
                    $display("FAIL flush_first_pc: got %h expected 00000200", o_pc);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout: got no valid expected pc 00000200");
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        tick(1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            tick(1'b0, 32'h0, 1'b0);
            checks++;
            if (o_rq !== 1'b1 || o_ad !== e) begin
                errors++;
                $display("FAIL wrap_addr %0d: got req %b addr %h expected 1 %h", i, o_rq, o_ad, e);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        reset_dut();
        repeat (4) tick(1'b0, 32'h0, 1'b1);
        #1;
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got valid %b expected 1", valid_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b0 || pc_o !== 32'h0) begin
            errors++;
            $display("FAIL areset_drop: got valid %b req %b pc %h expected 0 0 0", valid_o, imem_req_o, pc_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(1'b0, 32'h0, 1'b0);
        checks++;
        if (o_rq !== 1'b1 || o_ad !== RESET_PC) begin
            errors++;
            $display("FAIL areset_restart: got req %b addr %h expected 1 %h", o_rq, o_ad, RESET_PC);
        end
        for (int i = 0; i < 5 && !found; i++) begin
            tick(1'b0, 32'h0, 1'b0);
            if (o_v === 1'b1) begin
                found = 1'b1;
                checks++;
                if (o_pc !== RESET_PC) begin
                    errors++;
                    $display("FAIL areset_first_pc: got %h expected %h", o_pc, RESET_PC);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL areset_timeout: got no valid expected pc %h", RESET_PC);
        end
    endtask

    task automatic test_random();
        logic        br;
        logic        st;
        logic [31:0] ta;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            br = $urandom_range(0, 24) == 0;
            st = $urandom_range(0, 3) == 0;
            ta = $urandom;
            ta[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) ta = 32'hFFFF_FFF0;
            tick(br, ta, st);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_stall_full();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
